// File: rtl/vgatext_pkg.sv
// Shared definitions for the vgatext design: ASCII codes, text geometry, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   CH_*        ASCII codes used when rendering numeric fields
//   COLS/ROWS   default text-mode geometry
//   state_t     two-state writer FSM encoding
//   digit_char  maps a decimal digit 0..9 to its ASCII code
package vgatext_pkg;

   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_COLON = 8'h3A;
   localparam logic [7:0] CH_DOT   = 8'h2E;
   localparam logic [7:0] CH_QMARK = 8'h3F;

   localparam int COLS = 80;
   localparam int ROWS = 30;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return CH_ZERO + {4'h0, d};
   endfunction

endpackage

// File: rtl/clock_text_writer_bin2dec60.sv
// Splits a 6-bit binary value into decimal tens and units by compare-subtract.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of the input).
//
// Ports:
//   bin    in  6  binary value, nominally 0..59 (60..63 give tens=6, units=0..3)
//   tens   out 4  tens digit
//   units  out 4  units digit
module bin2dec60 (
   input  logic [5:0] bin,
   output logic [3:0] tens,
   output logic [3:0] units
);

   // Out-of-range 60..63 is passed through as tens=6 rather than clamped so
   // a misbehaving upstream counter is visible on screen.
   always_comb begin
      tens  = 4'd0;
      units = 4'(bin);
      if (bin >= 6'd60) begin
         tens  = 4'd6;
         units = 4'(bin - 6'd60);
      end else if (bin >= 6'd50) begin
         tens  = 4'd5;
         units = 4'(bin - 6'd50);
      end else if (bin >= 6'd40) begin
         tens  = 4'd4;
         units = 4'(bin - 6'd40);
      end else if (bin >= 6'd30) begin
         tens  = 4'd3;
         units = 4'(bin - 6'd30);
      end else if (bin >= 6'd20) begin
         tens  = 4'd2;
         units = 4'(bin - 6'd20);
      end else if (bin >= 6'd10) begin
         tens  = 4'd1;
         units = 4'(bin - 6'd10);
      end
   end

endmodule

// File: rtl/clock_text_writer.sv
// Renders the stopwatch min/sec/dsec as "MM:SS.D" into text-mode character RAM.
// Latency: first write request one cycle after the edge that samples a change; 7 cycles per string.
// Backpressure: outputs held stable while wr_ready is low; stalls indefinitely.
//
// Ports:
//   clk       in   1       system clock, rising edge
//   reset     in   1       synchronous active-high reset
//   dsec      in   4       tenths of a second (10..15 shown as '?')
//   sec       in   6       seconds
//   min       in   6       minutes
//   wr_en     out  1       character write request
//   wr_addr   out  ADDR_W  character RAM address (BASE + idx)
//   wr_data   out  8       ASCII code
//   wr_ready  in   1       write accepted when wr_en & wr_ready
//   busy      out  1       string update in progress
module clock_text_writer #(
   parameter int COLS   = vgatext_pkg::COLS,
   parameter int ROW    = 0,
   parameter int COL    = 0,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        dsec,
   input  logic [5:0]        sec,
   input  logic [5:0]        min,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic              wr_ready,
   output logic              busy
);

   import vgatext_pkg::*;

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ROW * COLS + COL);
   localparam logic [2:0]        LAST_IDX = 3'd6;

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [5:0] snap_min_q, snap_min_d;
   logic [5:0] snap_sec_q, snap_sec_d;
   logic [3:0] snap_dsec_q, snap_dsec_d;
   logic       dirty_q, dirty_d;

   logic       changed;
   logic [3:0] min_tens, min_units;
   logic [3:0] sec_tens, sec_units;
   logic [7:0] char_sel;

   // Digits come from the snapshot only, so the string on screen is always
   // one consistent time even if the counter ticks mid-update.
   bin2dec60 u_min (
      .bin   (snap_min_q),
      .tens  (min_tens),
      .units (min_units)
   );

   bin2dec60 u_sec (
      .bin   (snap_sec_q),
      .tens  (sec_tens),
      .units (sec_units)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= 3'd0;
         snap_min_q  <= 6'd0;
         snap_sec_q  <= 6'd0;
         snap_dsec_q <= 4'd0;
         dirty_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         snap_min_q  <= snap_min_d;
         snap_sec_q  <= snap_sec_d;
         snap_dsec_q <= snap_dsec_d;
         dirty_q     <= dirty_d;
      end
   end

   assign changed = ({min, sec, dsec} != {snap_min_q, snap_sec_q, snap_dsec_q});

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      snap_min_d  = snap_min_q;
      snap_sec_d  = snap_sec_q;
      snap_dsec_d = snap_dsec_q;
      dirty_d     = dirty_q;
      case (state_q)
         IDLE: begin
            // dirty guarantees one rewrite after reset even when the inputs
            // happen to equal the cleared snapshot.
            if (changed || dirty_q) begin
               snap_min_d  = min;
               snap_sec_d  = sec;
               snap_dsec_d = dsec;
               dirty_d     = 1'b0;
               idx_d       = 3'd0;
               state_d     = WRITE;
            end
         end
         WRITE: begin
            if (wr_ready) begin
               if (idx_q == LAST_IDX) begin
                  // idx parks at 0 so wr_addr rests at BASE while idle.
                  idx_d   = 3'd0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 3'd0;
         end
      endcase
   end

   // Character selected by position in "MM:SS.D"
   always_comb begin
      char_sel = 8'h00;
      case (idx_q)
         3'd0: char_sel = digit_char(min_tens);
         3'd1: char_sel = digit_char(min_units);
         3'd2: char_sel = CH_COLON;
         3'd3: char_sel = digit_char(sec_tens);
         3'd4: char_sel = digit_char(sec_units);
         3'd5: char_sel = CH_DOT;
         3'd6: char_sel = (snap_dsec_q > 4'd9) ? CH_QMARK : digit_char(snap_dsec_q);
         default: char_sel = 8'h00;
      endcase
   end

   // Output logic
   always_comb begin
      wr_en   = 1'b0;
      busy    = 1'b0;
      wr_data = 8'h00;
      wr_addr = BASE + ADDR_W'(idx_q);
      if (state_q == WRITE) begin
         wr_en   = 1'b1;
         busy    = 1'b1;
         wr_data = char_sel;
      end
   end

endmodule
